// File: rtl/prco_fetch_pkg.sv
// ISA opcodes, fetch-stage constants, FSM state encoding and FIFO entry layout for prco_fetch.
// FETCH_HALTED exists only when PRCO_FETCH_HALT_EN is defined.
package prco_fetch_pkg;

  localparam int PRCO_XLEN       = 16;
  localparam int PRCO_OP_BITS    = 5;
  localparam int PRCO_FIFO_DEPTH = 2;

  localparam logic [PRCO_OP_BITS-1:0] PRCO_OP_NOP  = 5'h00;
  localparam logic [PRCO_OP_BITS-1:0] PRCO_OP_HALT = 5'h1F;

  localparam logic [PRCO_XLEN-1:0] PRCO_RESET_PC = 16'h0000;

  typedef enum logic [1:0] {
    FETCH_IDLE   = 2'd0,
    FETCH_REQ    = 2'd1
`ifdef PRCO_FETCH_HALT_EN
    , FETCH_HALTED = 2'd2
`endif
  } fetch_state_e;

  typedef struct packed {
    logic [PRCO_XLEN-1:0] pc;
    logic [PRCO_XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [PRCO_OP_BITS-1:0] opcode_of(input logic [PRCO_XLEN-1:0] word);
    return word[PRCO_XLEN-1 -: PRCO_OP_BITS];
  endfunction

endpackage

// File: rtl/prco_fetch_fifo.sv
// Synchronous prefetch FIFO with push, pop, flush and occupancy count.
// Flush wins over push/pop; DEPTH must be a power of two so pointers wrap naturally.
module prco_fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CW-1:0]    count_o,
  output logic             empty_o
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_push  = push_i && (count_q != DEPTH_C);
    do_pop   = pop_i && (count_q != '0);
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; the count alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/prco_fetch.sv
// PRCO instruction fetch: owns the PC, issues one-word memory reads, buffers them for the decoder.
// Optional feature macro: PRCO_FETCH_HALT_EN (stop fetching after a HALT word is buffered).
module prco_fetch
  import prco_fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC   = PRCO_RESET_PC,
  parameter int          FIFO_DEPTH = PRCO_FIFO_DEPTH
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic         i_branch,
  input  logic [15:0]  i_branch_addr,
  output logic         q_mem_req,
  output logic [15:0]  q_mem_addr,
  input  logic         i_mem_ack,
  input  logic [15:0]  i_mem_data,
  output logic         q_valid,
  input  logic         i_dec_ready,
  output logic [15:0]  q_instr,
  output logic [15:0]  q_pc,
  output fetch_state_e q_dbg_state
);

  // Memory handshake: q_mem_req/q_mem_addr are held until i_mem_ack; the word is valid
  // in the ack cycle. Decoder handshake: an entry moves when q_valid && i_dec_ready.

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  fetch_state_e state_q, state_d;
  logic [15:0]  pc_q, pc_d;
  logic [15:0]  tgt_q, tgt_d;
  logic         drop_q, drop_d;

  logic         push, pop;
  logic [CW-1:0] fifo_count;
  logic [CW:0]  count_after;
  logic         room_after;
  logic         fifo_empty;
  fetch_entry_t fifo_head;

  assign push        = (state_q == FETCH_REQ) && i_mem_ack && !drop_q && !i_branch;
  assign pop         = q_valid && i_dec_ready && !i_branch;
  assign count_after = {1'b0, fifo_count} + {{CW{1'b0}}, push} - {{CW{1'b0}}, pop};
  assign room_after  = count_after < DEPTH_C;

  prco_fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk_i   (i_clk),
    .rst_ni  (i_reset_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (i_branch),
    .wdata_i ({pc_q, i_mem_data}),
    .rdata_o (fifo_head),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q <= FETCH_IDLE;
      pc_q    <= RESET_PC;
      tgt_q   <= RESET_PC;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    drop_d  = drop_q;
    if (i_branch) begin
      // An unacked request cannot be withdrawn: remember the target and discard its data.
      if ((state_q == FETCH_REQ) && !i_mem_ack) begin
        drop_d = 1'b1;
        tgt_d  = i_branch_addr;
      end else begin
        drop_d  = 1'b0;
        pc_d    = i_branch_addr;
        state_d = FETCH_REQ;
      end
    end else begin
      case (state_q)
        FETCH_IDLE: begin
          if ({1'b0, fifo_count} < DEPTH_C) state_d = FETCH_REQ;
        end
        FETCH_REQ: begin
          if (i_mem_ack) begin
            if (drop_q) begin
              drop_d = 1'b0;
              pc_d   = tgt_q;
            end else begin
              pc_d = pc_q + 16'd1;
`ifdef PRCO_FETCH_HALT_EN
              if (opcode_of(i_mem_data) == PRCO_OP_HALT) state_d = FETCH_HALTED;
              else if (!room_after) state_d = FETCH_IDLE;
`else
              if (!room_after) state_d = FETCH_IDLE;
`endif
            end
          end
        end
`ifdef PRCO_FETCH_HALT_EN
        FETCH_HALTED: state_d = FETCH_HALTED;
`endif
        default: state_d = FETCH_IDLE;
      endcase
    end
  end

  always_comb begin
    q_mem_req   = (state_q == FETCH_REQ);
    q_mem_addr  = pc_q;
    q_valid     = !fifo_empty;
    q_dbg_state = state_q;
    if (fifo_empty) begin
      q_pc    = 16'h0000;
      q_instr = {PRCO_OP_NOP, {(16-PRCO_OP_BITS){1'b0}}};
    end else begin
      q_pc    = fifo_head.pc;
      q_instr = fifo_head.instr;
    end
  end

endmodule
